vmicro16_hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the vmicro16 core. It watches the IF/ID and ID/EX stages, the EX branch outcome and the MEM-stage bus handshake. From these it drives the `stall`, `jmping` (flush) and bubble controls consumed by the decode/execute stage registers. It also owns the HALT wait state, a memory-timeout watchdog and a saturating stall-cycle performance counter.

---
 rtl/vmicro16_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_vmicro16_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vmicro16_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vmicro16_hazard_ctrl
//  Brief    : Pipeline stall/flush/bubble controller with HALT wait state,
//             MEM-wait watchdog and saturating stall-cycle counter.
//  Revision : 1.0
// ============================================================================
module vmicro16_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ifid_valid,
  input  logic [2:0]             ifid_rs1,
  input  logic [2:0]             ifid_rs2,
  input  logic                   ifid_uses_rs1,
  input  logic                   ifid_uses_rs2,
  input  logic                   idex_valid,
  input  logic [2:0]             idex_rd,
  input  logic                   idex_has_we,
  input  logic                   idex_has_mem,
  input  logic                   idex_has_mem_we,
  input  logic                   idex_halt,
  input  logic                   exme_br_taken,
  input  logic                   mem_start,
  input  logic                   mem_ack,
  input  logic                   resume,
  output logic                   stall,
  output logic                   bubble,
  output logic                   jmping,
  output logic                   halted,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int c_WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0]    c_TIMEOUT    = c_WAIT_W'(MEM_TIMEOUT);
  localparam logic [STALL_CNT_W-1:0] c_CNT_MAX    = '1;
  localparam logic                   c_TIMEOUT_EN = (MEM_TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [c_WAIT_W-1:0]      r_wait_cnt;
  logic [STALL_CNT_W-1:0]   r_stall_count;
  logic                     r_halted;
  logic                     r_mem_timeout;

  logic w_lu;
  logic w_stall;
  logic w_bubble;
  logic w_jmping;
  logic w_wait_load;
  logic w_wait_inc;
  logic w_set_timeout;

  // Load-use: a load in EX whose destination feeds a source read in ID.
  assign w_lu = ifid_valid & idex_valid & idex_has_mem & ~idex_has_mem_we & idex_has_we &
                ((ifid_uses_rs1 & (ifid_rs1 == idex_rd)) |
                 (ifid_uses_rs2 & (ifid_rs2 == idex_rd)));

  always_comb begin
    w_next_state  = r_state;
    w_stall       = 1'b0;
    w_bubble      = 1'b0;
    w_jmping      = 1'b0;
    w_wait_load   = 1'b0;
    w_wait_inc    = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mem_start & ~mem_ack) begin
          w_stall      = 1'b1;
          w_wait_load  = 1'b1;
          w_next_state = ST_MEM_WAIT;
        end else if (exme_br_taken) begin
          w_jmping = 1'b1;
        end else if (idex_valid & idex_halt) begin
          w_stall      = 1'b1;
          w_next_state = ST_HALTED;
        end else if (w_lu) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // EX is frozen here, so branch/halt/load-use are re-seen once back in RUN.
        if (mem_ack) begin
          w_next_state = ST_RUN;
        end else if (c_TIMEOUT_EN && (r_wait_cnt == c_TIMEOUT)) begin
          w_set_timeout = 1'b1;
          w_next_state  = ST_RUN;
        end else begin
          w_stall    = 1'b1;
          w_wait_inc = 1'b1;
        end
      end
      ST_HALTED: begin
        if (resume) begin
          w_next_state = ST_RUN;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_stall_count <= '0;
      r_halted      <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_halted <= (w_next_state == ST_HALTED);
      if (w_set_timeout) begin
        r_mem_timeout <= 1'b1;
      end
      if (w_wait_load) begin
        r_wait_cnt <= c_WAIT_W'(1);
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
      end
      if (w_stall && (r_stall_count != c_CNT_MAX)) begin
        r_stall_count <= r_stall_count + STALL_CNT_W'(1);
      end
    end
  end

  // Combinational controls are held low for the whole of reset.
  assign stall       = w_stall  & ~reset;
  assign bubble      = w_bubble & ~reset;
  assign jmping      = w_jmping & ~reset;
  assign halted      = r_halted;
  assign mem_timeout = r_mem_timeout;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_vmicro16_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vmicro16_hazard_ctrl
//  Brief    : Directed self-checking bench for vmicro16_hazard_ctrl
//             (MEM_TIMEOUT=8, STALL_CNT_W=4).
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vmicro16_hazard_ctrl;

  localparam int c_T = 8;
  localparam int c_W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           ifid_valid, ifid_uses_rs1, ifid_uses_rs2;
  logic [2:0]     ifid_rs1, ifid_rs2, idex_rd;
  logic           idex_valid, idex_has_we, idex_has_mem, idex_has_mem_we, idex_halt;
  logic           exme_br_taken, mem_start, mem_ack, resume;
  logic           stall, bubble, jmping, halted, mem_timeout;
  logic [c_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vmicro16_hazard_ctrl #(.MEM_TIMEOUT(c_T), .STALL_CNT_W(c_W)) dut (
    .clk(clk), .reset(reset),
    .ifid_valid(ifid_valid), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_valid(idex_valid), .idex_rd(idex_rd), .idex_has_we(idex_has_we),
    .idex_has_mem(idex_has_mem), .idex_has_mem_we(idex_has_mem_we),
    .idex_halt(idex_halt), .exme_br_taken(exme_br_taken),
    .mem_start(mem_start), .mem_ack(mem_ack), .resume(resume),
    .stall(stall), .bubble(bubble), .jmping(jmping), .halted(halted),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  task automatic clear_inputs();
    ifid_valid = 0; ifid_uses_rs1 = 0; ifid_uses_rs2 = 0;
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rd = 0;
    idex_valid = 0; idex_has_we = 0; idex_has_mem = 0; idex_has_mem_we = 0;
    idex_halt = 0; exme_br_taken = 0; mem_start = 0; mem_ack = 0; resume = 0;
  endtask

  // Advance one edge and settle; registered outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    mem_start = 1; exme_br_taken = 1;
    tick(); tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (jmping !== 1'b0) begin errors++; $display("FAIL reset_jmping got %b want 0", jmping); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", bubble); end
    checks++; if (halted !== 1'b0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", halted, mem_timeout); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", stall_count); end
    apply_reset();
  endtask

  task automatic test_load_use();
    ifid_valid = 1; ifid_uses_rs2 = 1; ifid_rs2 = 3;
    idex_valid = 1; idex_rd = 3; idex_has_mem = 1; idex_has_we = 1; idex_has_mem_we = 0;
    #1;
    checks++; if ({stall, bubble, jmping} !== 3'b110) begin errors++; $display("FAIL lu_rs2 got %b want 110", {stall, bubble, jmping}); end
    tick();
    idex_valid = 0; // the bubble now occupies ID/EX
    #1;
    checks++; if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL lu_after got %b want 00", {stall, bubble}); end
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_count got %0d want 1", stall_count); end
    idex_valid = 1; idex_has_mem_we = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_store got %b want 0", stall); end
    idex_has_mem_we = 0; ifid_uses_rs2 = 0; ifid_uses_rs1 = 1; ifid_rs1 = 5; idex_rd = 5;
    #1;
    checks++; if ({stall, bubble} !== 2'b11) begin errors++; $display("FAIL lu_rs1 got %b want 11", {stall, bubble}); end
    ifid_uses_rs1 = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_unused got %b want 0", stall); end
    apply_reset();
  endtask

  task automatic test_branch();
    exme_br_taken = 1;
    #1;
    checks++; if ({stall, jmping} !== 2'b01) begin errors++; $display("FAIL br_run got %b want 01", {stall, jmping}); end
    tick();
    exme_br_taken = 0;
    #1;
    checks++; if (jmping !== 1'b0) begin errors++; $display("FAIL br_once got %b want 0", jmping); end
    exme_br_taken = 1; mem_start = 1;
    #1;
    checks++; if ({stall, jmping} !== 2'b10) begin errors++; $display("FAIL br_memstart got %b want 10", {stall, jmping}); end
    tick();
    mem_start = 0;
    #1;
    checks++; if ({stall, jmping} !== 2'b10) begin errors++; $display("FAIL br_memwait got %b want 10", {stall, jmping}); end
    tick();
    mem_ack = 1;
    #1;
    checks++; if ({stall, jmping} !== 2'b00) begin errors++; $display("FAIL br_ack got %b want 00", {stall, jmping}); end
    tick();
    mem_ack = 0;
    #1;
    checks++; if ({stall, jmping} !== 2'b01) begin errors++; $display("FAIL br_after_ack got %b want 01", {stall, jmping}); end
    apply_reset();
  endtask

  task automatic test_mem_wait();
    mem_start = 1; mem_ack = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mem_zero_wait got %b want 0", stall); end
    tick();
    mem_ack = 0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mem_c0 got %b want 1", stall); end
    tick();
    mem_start = 0;
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mem_c%0d got %b want 1", i, stall); end
      tick();
    end
    mem_ack = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mem_ackcyc got %b want 0", stall); end
    tick();
    mem_ack = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mem_post got %b want 0", stall); end
    checks++; if (stall_count !== 4'd4) begin errors++; $display("FAIL mem_count got %0d want 4", stall_count); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL mem_no_to got %b want 0", mem_timeout); end
    apply_reset();
  endtask

  task automatic test_watchdog();
    int n;
    n = 0;
    mem_start = 1;
    #1;
    while (stall && n < 20) begin
      n++;
      tick();
      mem_start = 0;
      #1;
    end
    checks++; if (n != c_T) begin errors++; $display("FAIL wd_stall_cycles got %0d want %0d", n, c_T); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL wd_before_edge got %b want 0", mem_timeout); end
    tick();
    checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL wd_set got %b want 1", mem_timeout); end
    checks++; if (stall_count !== 4'd8) begin errors++; $display("FAIL wd_count got %0d want 8", stall_count); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if ({mem_timeout, stall} !== 2'b10) begin errors++; $display("FAIL wd_sticky got %b want 10", {mem_timeout, stall}); end
    apply_reset();
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL wd_clear got %b want 0", mem_timeout); end
  endtask

  task automatic test_halt();
    resume = 1;
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_resume_ignored got %b want 0", halted); end
    resume = 0;
    idex_valid = 1; idex_halt = 1;
    #1;
    checks++; if ({stall, halted} !== 2'b10) begin errors++; $display("FAIL halt_seen got %b want 10", {stall, halted}); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_rise got %b want 1", halted); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL halt_hold%0d got %b want 1", i, stall); end
      tick();
    end
    checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_count got %0d want 15", stall_count); end
    resume = 1;
    #1;
    checks++; if ({stall, halted} !== 2'b01) begin errors++; $display("FAIL resume_cyc got %b want 01", {stall, halted}); end
    tick();
    resume = 0; idex_valid = 0; idex_halt = 0;
    #1;
    checks++; if ({stall, halted} !== 2'b00) begin errors++; $display("FAIL resume_after got %b want 00", {stall, halted}); end
    checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stall_count); end
    idex_valid = 1; idex_halt = 1;
    tick(); tick();
    #2;
    reset = 1;
    #1;
    checks++; if ({stall, bubble, jmping, halted, mem_timeout} !== 5'b0) begin errors++; $display("FAIL halt_async_reset got %b want 00000", {stall, bubble, jmping, halted, mem_timeout}); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL halt_reset_count got %0d want 0", stall_count); end
    apply_reset();
  endtask

  task automatic test_priority();
    // HALT outranks load-use; a zero-wait access does not mask a branch.
    ifid_valid = 1; ifid_uses_rs1 = 1; ifid_rs1 = 2;
    idex_valid = 1; idex_rd = 2; idex_has_mem = 1; idex_has_we = 1; idex_halt = 1;
    #1;
    checks++; if ({stall, bubble} !== 2'b10) begin errors++; $display("FAIL prio_halt_lu got %b want 10", {stall, bubble}); end
    idex_halt = 0; exme_br_taken = 1; mem_start = 1; mem_ack = 1;
    #1;
    checks++; if ({stall, bubble, jmping} !== 3'b001) begin errors++; $display("FAIL prio_br_zw got %b want 001", {stall, bubble, jmping}); end
    apply_reset();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_watchdog();
    test_halt();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
